// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_filter_pkg;

   // Legal synchroniser depth range.
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Default polarity: every channel is asserted when its pad is low.
   localparam logic ACTIVE_LOW_BIT_DEF = 1'b1;
   localparam int   NUM_CH_DEF         = 8;
   localparam logic [NUM_CH_DEF-1:0] ACTIVE_LOW_DEF = {NUM_CH_DEF{ACTIVE_LOW_BIT_DEF}};

   // A programmed threshold of 0 behaves as 1 so a channel can never stall.
   function automatic int unsigned eff_len(input int unsigned len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchroniser, glitch filter, fast release, edge pulses, sticky flag.
// Latency: SYNC_STAGES + eff_len edges (filtered), SYNC_STAGES + 1 (fast release).
// Backpressure: none; free-running, outputs update every cycle.
//
// Ports: clock/reset_n; sig_in raw async input; filt_len shared threshold;
// fast_rel mode; clr_evt W1C for evt_flag; sig_out/sig_act filtered level;
// rise_pls/fall_pls one-cycle edges; evt_flag sticky change flag.
module sync_filter_ch
   import sync_filter_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   CNT_W       = 4,
   parameter logic ACT_LOW     = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sig_in,
   input  logic [CNT_W-1:0] filt_len,
   input  logic             fast_rel,
   input  logic             clr_evt,
   output logic             sig_out,
   output logic             sig_act,
   output logic             rise_pls,
   output logic             fall_pls,
   output logic             evt_flag
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
      $error("sync_filter_ch: SYNC_STAGES out of range");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   act_q;
   logic                   act_nxt;
   logic                   syn_act;
   logic [31:0]            cnt_p1;
   logic [31:0]            len_eff;

   // Plain flop chain, no logic between stages; resets to the inactive pad level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{ACT_LOW}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   assign syn_act = sync_q[SYNC_STAGES-1] ^ ACT_LOW;

   // Compare in 32 bits so a threshold lowered below the running count
   // still fires instead of wrapping.
   assign cnt_p1  = 32'(cnt_q) + 32'd1;
   assign len_eff = eff_len(32'(filt_len));

   always_comb begin
      act_nxt = act_q;
      cnt_nxt = cnt_q;
      if (syn_act == act_q) begin
         cnt_nxt = '0;
      end else if (fast_rel && act_q) begin
         // Release bypasses the filter; assertion never does.
         act_nxt = 1'b0;
         cnt_nxt = '0;
      end else if (cnt_p1 >= len_eff) begin
         act_nxt = ~act_q;
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt_p1[CNT_W-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         act_q    <= 1'b0;
         rise_pls <= 1'b0;
         fall_pls <= 1'b0;
         evt_flag <= 1'b0;
      end else begin
         cnt_q    <= cnt_nxt;
         act_q    <= act_nxt;
         // Pulses come from old/new level, so they only fire on a real change.
         rise_pls <= ~act_q & act_nxt;
         fall_pls <= act_q & ~act_nxt;
         // A change in the same cycle as a clear keeps the flag set.
         evt_flag <= (act_q ^ act_nxt) | (evt_flag & ~clr_evt);
      end
   end

   assign sig_act = act_q;
   assign sig_out = act_q ^ ACT_LOW;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input synchroniser and glitch filter for pad inputs.
// Latency: SYNC_STAGES + eff_len edges (filtered), SYNC_STAGES + 1 (fast release).
// Backpressure: none; free-running, outputs update every cycle.
//
// Ports: clock/reset_n; sig_in[NUM_CH] async pads; filt_len shared threshold;
// fast_rel/clr_evt per channel; sig_out, sig_act, rise_pls, fall_pls, evt_flag
// per channel in the clock domain. vccd1/vssd1 exist only with USE_POWER_PINS.
module sync_filter
   import sync_filter_pkg::*;
#(
   parameter int                NUM_CH      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter int                CNT_W       = 4,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW  = {NUM_CH{ACTIVE_LOW_BIT_DEF}}
) (
`ifdef USE_POWER_PINS
   inout  wire               vccd1,
   inout  wire               vssd1,
`endif
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] sig_in,
   input  logic [CNT_W-1:0]  filt_len,
   input  logic [NUM_CH-1:0] fast_rel,
   input  logic [NUM_CH-1:0] clr_evt,
   output logic [NUM_CH-1:0] sig_out,
   output logic [NUM_CH-1:0] sig_act,
   output logic [NUM_CH-1:0] rise_pls,
   output logic [NUM_CH-1:0] fall_pls,
   output logic [NUM_CH-1:0] evt_flag
);

   // Channels share only clock, reset and the threshold; no cross-channel state.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_filter_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W),
         .ACT_LOW     (ACTIVE_LOW[i])
      ) u_ch (
         .clock    (clock),
         .reset_n  (reset_n),
         .sig_in   (sig_in[i]),
         .filt_len (filt_len),
         .fast_rel (fast_rel[i]),
         .clr_evt  (clr_evt[i]),
         .sig_out  (sig_out[i]),
         .sig_act  (sig_act[i]),
         .rise_pls (rise_pls[i]),
         .fall_pls (fall_pls[i]),
         .evt_flag (evt_flag[i])
      );
   end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: 8 active-low channels, 2 sync stages, 4-bit counter.
module tb_sync_filter;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] sig_in = 8'hFF;
   logic [3:0] filt_len = 4'd3;
   logic [7:0] fast_rel = 8'h00;
   logic [7:0] clr_evt = 8'h00;
   logic [7:0] sig_out, sig_act, rise_pls, fall_pls, evt_flag;

   int total = 0;
   int bad = 0;

   sync_filter #(
      .NUM_CH(8), .SYNC_STAGES(2), .CNT_W(4), .ACTIVE_LOW(8'hFF)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .sig_in   (sig_in),
      .filt_len (filt_len),
      .fast_rel (fast_rel),
      .clr_evt  (clr_evt),
      .sig_out  (sig_out),
      .sig_act  (sig_act),
      .rise_pls (rise_pls),
      .fall_pls (fall_pls),
      .evt_flag (evt_flag)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] sin;
      logic [3:0] flen;
      logic [7:0] clr;
      logic [7:0] act;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] evt;
   } vec_t;

   vec_t tbl[14];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Inputs must already be changed; first step is edge 1 of the latency count.
   task automatic wait_act(input int ch, input logic want, input int exp_n, input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (sig_act[ch] !== want && n < 40);
      chk({name, " latency"}, n, exp_n);
      chk({name, " pulse"}, want ? rise_pls[ch] : fall_pls[ch], 1);
      chk({name, " other pulse"}, want ? fall_pls[ch] : rise_pls[ch], 0);
      step();
      chk({name, " pulse width"}, rise_pls[ch] | fall_pls[ch], 0);
   endtask

   initial begin
      // ch0 asserts with filt_len=3 (toggles on edge 5), ch1 glitches for 2 cycles.
      tbl[0]  = '{8'hFC, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{8'hFC, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2]  = '{8'hFE, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[3]  = '{8'hFE, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[4]  = '{8'hFE, 4'd3, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
      tbl[5]  = '{8'hFE, 4'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[6]  = '{8'hFF, 4'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[7]  = '{8'hFF, 4'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[8]  = '{8'hFF, 4'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[9]  = '{8'hFF, 4'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[10] = '{8'hFF, 4'd3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      tbl[11] = '{8'hFF, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      tbl[12] = '{8'hFF, 4'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[13] = '{8'hFF, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset held with toggling inputs.
      for (int i = 0; i < 4; i++) begin
         sig_in = (i % 2 == 0) ? 8'h00 : 8'hA5;
         step();
         chk("rst sig_act", sig_act, 8'h00);
         chk("rst sig_out", sig_out, 8'hFF);
         chk("rst pulses", rise_pls | fall_pls, 8'h00);
         chk("rst evt", evt_flag, 8'h00);
      end
      sig_in = 8'hFF;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post-rst pulses", rise_pls | fall_pls, 8'h00);
         chk("post-rst evt", evt_flag, 8'h00);
      end

      // Table-driven cycle vectors.
      for (int r = 0; r < 14; r++) begin
         sig_in   = tbl[r].sin;
         filt_len = tbl[r].flen;
         clr_evt  = tbl[r].clr;
         step();
         chk($sformatf("tbl%0d sig_act", r), sig_act, tbl[r].act);
         chk($sformatf("tbl%0d sig_out", r), sig_out, tbl[r].act ^ 8'hFF);
         chk($sformatf("tbl%0d rise", r), rise_pls, tbl[r].rise);
         chk($sformatf("tbl%0d fall", r), fall_pls, tbl[r].fall);
         chk($sformatf("tbl%0d evt", r), evt_flag, tbl[r].evt);
      end
      clr_evt = 8'h00;

      // Glitch: 3-cycle low with filt_len=4 is rejected, then a held low asserts.
      filt_len = 4'd4;
      sig_in[1] = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 3) sig_in[1] = 1'b1;
         step();
         chk("glitch act1", sig_act[1], 0);
         chk("glitch pls1", rise_pls[1] | fall_pls[1], 0);
         chk("glitch evt1", evt_flag[1], 0);
      end
      sig_in[1] = 1'b0;
      wait_act(1, 1'b1, 6, "ch1 assert len4");
      chk("ch1 evt", evt_flag[1], 1);

      // Fast release on ch2 with filt_len=7.
      filt_len = 4'd7;
      fast_rel = 8'h04;
      sig_in[2] = 1'b0;
      wait_act(2, 1'b1, 9, "ch2 assert");
      sig_in[2] = 1'b1;
      wait_act(2, 1'b0, 3, "ch2 fast release");
      sig_in[2] = 1'b0;
      wait_act(2, 1'b1, 9, "ch2 reassert");
      fast_rel = 8'h00;

      // filt_len=0 behaves as 1.
      filt_len = 4'd0;
      sig_in[4] = 1'b0;
      wait_act(4, 1'b1, 3, "ch4 len0 assert");
      sig_in[4] = 1'b1;
      wait_act(4, 1'b0, 3, "ch4 len0 release");

      // Threshold lowered 15 -> 2 at count 5 fires on the next edge.
      filt_len = 4'd15;
      sig_in[5] = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("ch5 before lower", sig_act[5], 0);
      filt_len = 4'd2;
      step();
      chk("ch5 lowered act", sig_act[5], 1);
      chk("ch5 lowered rise", rise_pls[5], 1);

      // filt_len=15 needs 15 stable cycles, no wrap.
      filt_len = 4'd15;
      sig_in[6] = 1'b0;
      wait_act(6, 1'b1, 17, "ch6 len15");

      // Flag clear race on ch3, ch7 flag must be untouched.
      clr_evt = 8'hFF;
      step();
      clr_evt = 8'h00;
      chk("clear all", evt_flag, 8'h00);
      filt_len = 4'd1;
      sig_in[7] = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("ch7 act", sig_act[7], 1);
      chk("ch7 evt", evt_flag, 8'h80);
      sig_in[3] = 1'b0;
      clr_evt = 8'h08;
      for (int i = 0; i < 3; i++) step();
      chk("race act3", sig_act[3], 1);
      chk("race set wins", evt_flag, 8'h88);
      clr_evt = 8'h00;
      step();
      chk("race hold", evt_flag, 8'h88);
      clr_evt = 8'h08;
      step();
      chk("later clear", evt_flag, 8'h80);
      clr_evt = 8'h00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
